// File: rtl/bfm_add_pkg.sv
// Package for the bfm_add block.
// Purpose: shared widths and data types for the registered two-operand adder.
// Contents:
//   DEF_WIDTH - default operand/result width
//   data_t    - operand/result word at the default width
//   sum_t     - carry-extended sum at the default width
package bfm_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [DEF_WIDTH-1:0] data_t;
  typedef logic [DEF_WIDTH:0]   sum_t;

endpackage

// File: rtl/bfm_add_if.sv
// Interface for the bfm_add block.
// Purpose: groups the operand pair and the result into one bus.
// Signals:
//   A_s, B_s - operands, driven by the stimulus side every clock
//   res_o    - registered sum, driven by the adder
// Modports:
//   master - stimulus side (drives operands, observes result)
//   slave  - adder side (samples operands, drives result)
interface bfm_add_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] A_s;
  logic [WIDTH-1:0] B_s;
  logic [WIDTH-1:0] res_o;

  modport master (
    output A_s,
    output B_s,
    input  res_o
  );

  modport slave (
    input  A_s,
    input  B_s,
    output res_o
  );

endinterface

// File: rtl/bfm_add_alu.sv
// Combinational adder core for bfm_add.
// Purpose: unsigned add of two WIDTH-bit operands in WIDTH+1 bits.
//   Default build wraps modulo 2^WIDTH; with BFM_ADD_SAT_EN defined an
//   overflow clamps the result to all ones.
// Ports:
//   a, b - unsigned operands
//   y    - WIDTH-bit result (wrapped or saturated)
// Configuration macro: BFM_ADD_SAT_EN
module bfm_add_alu
  import bfm_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = {1'b0, a} + {1'b0, b};
`ifdef BFM_ADD_SAT_EN
    // Carry out means the true sum does not fit: clamp to the largest value.
    y = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    y = w_sum[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/bfm_add.sv
// Top level of the registered adder behind the stimulus wrapper.
// Purpose: one operand pair per clock in, sum out after PIPE_STAGES clocks.
//   No handshake; every clock is a valid transaction. Output comes only
//   from registers.
// Ports:
//   clk_i   - clock, rising edge
//   reset_i - synchronous active-high reset, clears every pipeline stage
//   io_bus  - bfm_add_if slave: A_s, B_s in, res_o out
// Parameters:
//   WIDTH       - operand/result width
//   PIPE_STAGES - result register stages, 1 or 2
// Configuration macro: BFM_ADD_SAT_EN (saturating add, see bfm_add_alu)
module bfm_add
  import bfm_add_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  bfm_add_if.slave   io_bus
);

  if ((PIPE_STAGES != 1) && (PIPE_STAGES != 2)) begin : g_bad_stages
    $error("bfm_add: PIPE_STAGES must be 1 or 2");
  end

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_pipe [PIPE_STAGES];

  bfm_add_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a (io_bus.A_s),
    .b (io_bus.B_s),
    .y (w_sum)
  );

  // Reset clears every stage so nothing issued before reset survives it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(PIPE_STAGES); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_sum;
      for (int i = 1; i < int'(PIPE_STAGES); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign io_bus.res_o = r_pipe[PIPE_STAGES-1];

endmodule

// File: tb/tb_bfm_add.sv
// Self-checking bench for bfm_add.
// Runs a 1-stage and a 2-stage instance side by side on the same operands.
// Expected results come from the vector table (hand-computed) or from a
// small unsigned-add reference; the 2-stage expectation is the 1-stage
// expectation of the previous clock, forced to 0 by reset.
module tb_bfm_add;

  logic clk;
  logic reset_i;

  bfm_add_if #(.WIDTH(8)) bus1 ();
  bfm_add_if #(.WIDTH(8)) bus2 ();

  bfm_add #(
    .WIDTH       (8),
    .PIPE_STAGES (1)
  ) u_dut1 (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io_bus  (bus1.slave)
  );

  bfm_add #(
    .WIDTH       (8),
    .PIPE_STAGES (2)
  ) u_dut2 (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io_bus  (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_wrap;
    logic [7:0] exp_sat;
  } vec_t;

  int         n_checks;
  int         n_fail;
  logic [7:0] prev1;

  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef BFM_ADD_SAT_EN
    return s[8] ? 8'hFF : s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: res_o=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one operand pair, clock once, then check both instances.
  task automatic cycle(input logic [7:0] a, input logic [7:0] b, input logic r,
                       input logic [7:0] exp_new, input string name);
    logic [7:0] e1;
    logic [7:0] e2;
    bus1.A_s = a;
    bus1.B_s = b;
    bus2.A_s = a;
    bus2.B_s = b;
    reset_i  = r;
    @(posedge clk);
    #1;
    e1 = r ? 8'h00 : exp_new;
    e2 = r ? 8'h00 : prev1;
    check({name, "/p1"}, bus1.res_o, e1);
    check({name, "/p2"}, bus2.res_o, e2);
    prev1 = e1;
  endtask

  vec_t vecs [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prev1    = 8'h00;

    vecs[0] = '{a: 8'hF0, b: 8'h20, exp_wrap: 8'h10, exp_sat: 8'hFF};
    vecs[1] = '{a: 8'hFF, b: 8'h01, exp_wrap: 8'h00, exp_sat: 8'hFF};
    vecs[2] = '{a: 8'h80, b: 8'h7F, exp_wrap: 8'hFF, exp_sat: 8'hFF};
    vecs[3] = '{a: 8'h00, b: 8'h00, exp_wrap: 8'h00, exp_sat: 8'h00};
    vecs[4] = '{a: 8'h12, b: 8'h34, exp_wrap: 8'h46, exp_sat: 8'h46};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, exp_wrap: 8'hFE, exp_sat: 8'hFF};
    vecs[6] = '{a: 8'h7F, b: 8'h01, exp_wrap: 8'h80, exp_sat: 8'h80};
    vecs[7] = '{a: 8'hA5, b: 8'h5A, exp_wrap: 8'hFF, exp_sat: 8'hFF};

    // Reset held for 3 edges with live operands: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      cycle(8'h55, 8'h22, 1'b1, 8'h00, "reset_hold");
    end
    // Release: 0x77 after 1 edge on p1, after 2 edges on p2.
    cycle(8'h55, 8'h22, 1'b0, 8'h77, "reset_release");
    cycle(8'h00, 8'h00, 1'b0, 8'h00, "reset_release_tail");

    // Table vectors, back-to-back.
    for (int i = 0; i < 8; i++) begin
`ifdef BFM_ADD_SAT_EN
      cycle(vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_sat, $sformatf("vec%0d", i));
`else
      cycle(vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_wrap, $sformatf("vec%0d", i));
`endif
    end

    // Latency: single pair then zeros.
    cycle(8'h01, 8'h02, 1'b0, 8'h03, "latency_pair");
    cycle(8'h00, 8'h00, 1'b0, 8'h00, "latency_z1");
    cycle(8'h00, 8'h00, 1'b0, 8'h00, "latency_z2");

    // Streaming (i, 2i mod 256).
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'(i);
      b = 8'((2 * i) % 256);
      cycle(a, b, 1'b0, ref_add(a, b), $sformatf("stream%0d", i));
    end

    // Mid-stream reset for one edge: in-flight results flushed.
    cycle(8'h10, 8'h01, 1'b0, 8'h11, "mid_pre0");
    cycle(8'h20, 8'h02, 1'b0, 8'h22, "mid_pre1");
    cycle(8'hAA, 8'h11, 1'b1, 8'h00, "mid_reset");
    cycle(8'h30, 8'h03, 1'b0, 8'h33, "mid_post0");
    cycle(8'h40, 8'h04, 1'b0, 8'h44, "mid_post1");
    cycle(8'h00, 8'h00, 1'b0, 8'h00, "mid_post2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
